// File: rtl/glb_intr_collector.sv
// Collects per-tile GLB interrupt pulses into sticky W1C status, level IRQs and per-class all-done pulses.
// Optional: define GLB_INTR_MASK_EN to add per-class tile mask registers at addresses 4..6.
module glb_intr_collector #(
    parameter int NUM_GLB_TILES  = 16,
    parameter int CFG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_GLB_TILES-1:0]  strm_f2g_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0]  strm_g2f_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0]  pcfg_g2f_interrupt_pulse,
    input  logic                      cfg_wr_en,
    input  logic                      cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [NUM_GLB_TILES-1:0]  cfg_wr_data,
    output logic [NUM_GLB_TILES-1:0]  cfg_rd_data,
    output logic                      cfg_rd_data_valid,
    output logic                      interrupt_f2g,
    output logic                      interrupt_g2f,
    output logic                      interrupt_pcfg,
    output logic [2:0]                all_done_pulse
);
    localparam int NC = 3;
    localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_EXPECTED = CFG_ADDR_WIDTH'(3);

    logic [NUM_GLB_TILES-1:0] pulse    [NC];
    logic [NUM_GLB_TILES-1:0] stat_all [NC];
`ifdef GLB_INTR_MASK_EN
    logic [NUM_GLB_TILES-1:0] mask_all [NC];
`endif
    logic [NC-1:0]            irq_all;
    logic [NC-1:0]            done_all;

    logic [NUM_GLB_TILES-1:0] expected_q, expected_d;
    logic                     exp_wr;
    logic [NUM_GLB_TILES-1:0] rd_data_q, rd_data_d;
    logic                     rd_valid_q;

    assign pulse[0] = strm_f2g_interrupt_pulse;
    assign pulse[1] = strm_g2f_interrupt_pulse;
    assign pulse[2] = pcfg_g2f_interrupt_pulse;

    assign exp_wr     = cfg_wr_en && (cfg_addr == ADDR_EXPECTED);
    assign expected_d = exp_wr ? cfg_wr_data : expected_q;

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_class
            logic [NUM_GLB_TILES-1:0] stat_q, stat_d;
            logic [NUM_GLB_TILES-1:0] seen_q, seen_d, seen_nxt;
            logic [NUM_GLB_TILES-1:0] mask_d;
            logic                     stat_wr;
            logic                     irq_q, irq_d;
            logic                     done_q, done_d;

            assign stat_wr = cfg_wr_en && (cfg_addr == CFG_ADDR_WIDTH'(gi));

`ifdef GLB_INTR_MASK_EN
            logic [NUM_GLB_TILES-1:0] mask_q;
            logic                     mask_wr;
            assign mask_wr = cfg_wr_en && (cfg_addr == CFG_ADDR_WIDTH'(gi + 4));
            assign mask_d  = mask_wr ? cfg_wr_data : mask_q;
            assign mask_all[gi] = mask_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) mask_q <= '0;
                else       mask_q <= mask_d;
            end
`else
            assign mask_d = '0;
`endif

            // Pulse set wins over a same-cycle W1C; the completion tracker ignores W1C entirely.
            always_comb begin
                stat_d   = (stat_q & ~(stat_wr ? cfg_wr_data : '0)) | pulse[gi];
                seen_nxt = (exp_wr ? '0 : seen_q) | pulse[gi];
                done_d   = (expected_q != '0) && ((seen_nxt & expected_q) == expected_q);
                seen_d   = done_d ? '0 : seen_nxt;
                irq_d    = |(stat_d & ~mask_d);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stat_q <= '0;
                    seen_q <= '0;
                    irq_q  <= 1'b0;
                    done_q <= 1'b0;
                end else begin
                    stat_q <= stat_d;
                    seen_q <= seen_d;
                    irq_q  <= irq_d;
                    done_q <= done_d;
                end
            end

            assign stat_all[gi] = stat_q;
            assign irq_all[gi]  = irq_q;
            assign done_all[gi] = done_q;
        end
    endgenerate

    // Read captures register contents before any same-cycle update.
    always_comb begin
        rd_data_d = '0;
        if (cfg_rd_en) begin
            for (int k = 0; k < NC; k++) begin
                if (cfg_addr == CFG_ADDR_WIDTH'(k)) rd_data_d = stat_all[k];
`ifdef GLB_INTR_MASK_EN
                if (cfg_addr == CFG_ADDR_WIDTH'(k + 4)) rd_data_d = mask_all[k];
`endif
            end
            if (cfg_addr == ADDR_EXPECTED) rd_data_d = expected_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            expected_q <= expected_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= cfg_rd_en;
        end
    end

    assign cfg_rd_data       = rd_data_q;
    assign cfg_rd_data_valid = rd_valid_q;
    assign interrupt_f2g     = irq_all[0];
    assign interrupt_g2f     = irq_all[1];
    assign interrupt_pcfg    = irq_all[2];
    assign all_done_pulse    = done_all;

endmodule

// File: tb/tb_glb_intr_collector.sv
// Self-checking bench for glb_intr_collector: directed scenarios plus random traffic against a reference model.
module tb_glb_intr_collector;
    localparam int N  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  f2g_p, g2f_p, pcfg_p;
    logic          wr_en, rd_en;
    logic [AW-1:0] addr;
    logic [N-1:0]  wdata;
    logic [N-1:0]  rd_data;
    logic          rd_valid;
    logic          irq_f2g, irq_g2f, irq_pcfg;
    logic [2:0]    done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_stat [3];
    logic [N-1:0] m_seen [3];
    logic [N-1:0] m_mask [3];
    logic [N-1:0] m_exp;
    logic [N-1:0] m_rd_data;
    logic         m_rd_valid;
    logic [2:0]   m_irq;
    logic [2:0]   m_done;

    glb_intr_collector #(.NUM_GLB_TILES(N), .CFG_ADDR_WIDTH(AW)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .strm_f2g_interrupt_pulse (f2g_p),
        .strm_g2f_interrupt_pulse (g2f_p),
        .pcfg_g2f_interrupt_pulse (pcfg_p),
        .cfg_wr_en                (wr_en),
        .cfg_rd_en                (rd_en),
        .cfg_addr                 (addr),
        .cfg_wr_data              (wdata),
        .cfg_rd_data              (rd_data),
        .cfg_rd_data_valid        (rd_valid),
        .interrupt_f2g            (irq_f2g),
        .interrupt_g2f            (irq_g2f),
        .interrupt_pcfg           (irq_pcfg),
        .all_done_pulse           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_stat[c] = '0;
            m_seen[c] = '0;
            m_mask[c] = '0;
        end
        m_exp      = '0;
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_irq      = '0;
        m_done     = '0;
    endtask

    // One clock of the behavioural model, applied with the inputs that were sampled at that edge.
    task automatic model_step(input logic [N-1:0] p0, input logic [N-1:0] p1, input logic [N-1:0] p2,
                              input logic w, input logic r, input int a, input logic [N-1:0] d);
        logic [N-1:0] p [3];
        logic [N-1:0] s;
        p[0] = p0; p[1] = p1; p[2] = p2;
        m_rd_valid = r;
        m_rd_data  = '0;
        if (r) begin
            if (a <= 2) m_rd_data = m_stat[a];
            else if (a == 3) m_rd_data = m_exp;
`ifdef GLB_INTR_MASK_EN
            else if (a <= 6) m_rd_data = m_mask[a-4];
`endif
        end
        for (int c = 0; c < 3; c++) begin
            s = (w && a == 3) ? '0 : m_seen[c];
            s = s | p[c];
            m_done[c] = (m_exp != 0) && ((s & m_exp) == m_exp);
            m_seen[c] = m_done[c] ? '0 : s;
            if (w && a == c) m_stat[c] = m_stat[c] & ~d;
            m_stat[c] = m_stat[c] | p[c];
`ifdef GLB_INTR_MASK_EN
            if (w && a == c + 4) m_mask[c] = d;
`endif
        end
        if (w && a == 3) m_exp = d;
        for (int c = 0; c < 3; c++) m_irq[c] = |(m_stat[c] & ~m_mask[c]);
    endtask

    // Drive one cycle of inputs, advance past the edge, and compare every output with the model.
    task automatic step(input logic [N-1:0] p0, input logic [N-1:0] p1, input logic [N-1:0] p2,
                        input logic w, input logic r, input int a, input logic [N-1:0] d);
        f2g_p = p0; g2f_p = p1; pcfg_p = p2;
        wr_en = w; rd_en = r; addr = AW'(a); wdata = d;
        @(posedge clk);
        #1;
        model_step(p0, p1, p2, w, r, a, d);
        chk("rd_data",  rd_data,  m_rd_data);
        chk("rd_valid", rd_valid, m_rd_valid);
        chk("irq_f2g",  irq_f2g,  m_irq[0]);
        chk("irq_g2f",  irq_g2f,  m_irq[1]);
        chk("irq_pcfg", irq_pcfg, m_irq[2]);
        chk("all_done", done,     m_done);
        if (w || r)
            $display("txn wr=%0d rd=%0d addr=%0d wdata=0x%04h rd_data=0x%04h valid=%0d done=%b",
                     w, r, a, d, rd_data, rd_valid, done);
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_irq"}, {irq_f2g, irq_g2f, irq_pcfg}, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        reset = 1'b1;
        f2g_p = '0; g2f_p = '0; pcfg_p = '0;
        wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;

        // Set then read back STAT_F2G
        step(16'h0008, '0, '0, 1'b0, 1'b0, 0, '0);
        chk("set_irq_f2g", irq_f2g, 1);
        idle();
        step('0, '0, '0, 1'b0, 1'b1, 0, '0);
        chk("set_rd_data", rd_data, 16'h0008);
        chk("set_rd_valid", rd_valid, 1);

        // W1C racing a set on the same bit
        step('0, 16'h0005, '0, 1'b0, 1'b0, 0, '0);
        step('0, 16'h0001, '0, 1'b1, 1'b0, 1, 16'h0005);
        chk("w1c_irq_g2f", irq_g2f, 1);
        step('0, '0, '0, 1'b0, 1'b1, 1, '0);
        chk("w1c_rd_g2f", rd_data, 16'h0001);

        // All-done on pcfg, two rounds
        step('0, '0, '0, 1'b1, 1'b0, 3, 16'h000F);
        for (int round = 0; round < 2; round++) begin
            for (int t = 0; t < 3; t++) begin
                step('0, '0, N'(1 << t), 1'b0, 1'b0, 0, '0);
                chk("alldone_early", done, 0);
            end
            step('0, '0, 16'h0008, 1'b0, 1'b0, 0, '0);
            chk("alldone_fire", done, 3'b100);
            idle();
            chk("alldone_once", done, 0);
        end

        // Rewriting EXPECTED discards already-seen tiles
        step('0, '0, '0, 1'b1, 1'b0, 3, '0);
        step(16'h0003, '0, '0, 1'b0, 1'b0, 0, '0);
        chk("exp0_nofire", done, 0);
        step('0, '0, '0, 1'b1, 1'b0, 3, 16'h0003);
        chk("exprw_nofire", done, 0);
        step(16'h0001, '0, '0, 1'b0, 1'b0, 0, '0);
        chk("exprw_partial", done, 0);
        step(16'h0002, '0, '0, 1'b0, 1'b0, 0, '0);
        chk("exprw_fire", done, 3'b001);

`ifdef GLB_INTR_MASK_EN
        step('0, '0, '0, 1'b1, 1'b0, 0, 16'hFFFF);
        step('0, '0, '0, 1'b1, 1'b0, 4, 16'h0001);
        step(16'h0001, '0, '0, 1'b0, 1'b0, 0, '0);
        chk("mask_irq_off", irq_f2g, 0);
        step('0, '0, '0, 1'b0, 1'b1, 0, '0);
        chk("mask_stat", rd_data, 16'h0001);
        step('0, '0, '0, 1'b1, 1'b0, 4, '0);
        chk("unmask_irq_on", irq_f2g, 1);
`else
        step('0, '0, '0, 1'b1, 1'b0, 4, 16'h00FF);
        step('0, '0, '0, 1'b0, 1'b1, 4, '0);
        chk("nomask_rd4", rd_data, 0);
`endif
        step('0, '0, '0, 1'b1, 1'b0, 7, 16'hFFFF);
        step('0, '0, '0, 1'b0, 1'b1, 7, '0);
        chk("reserved_rd7", rd_data, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] p0, p1, p2, d;
            logic w, r;
            int a;
            p0 = N'($urandom & $urandom & $urandom);
            p1 = N'($urandom & $urandom & $urandom);
            p2 = N'($urandom & $urandom & $urandom);
            w  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 1) == 1);
            a  = $urandom_range(0, 7);
            d  = (a == 3) ? N'($urandom_range(0, 15)) : N'($urandom);
            step(p0, p1, p2, w, r, a, d);
        end

        // Reset mid-traffic: outputs drop immediately, status reads zero afterwards
        f2g_p = 16'hFFFF; g2f_p = 16'hFFFF; pcfg_p = 16'hFFFF;
        wr_en = 1'b0; rd_en = 1'b1; addr = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        f2g_p = '0; g2f_p = '0; pcfg_p = '0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            step('0, '0, '0, 1'b0, 1'b1, c, '0);
            chk("postreset_stat", rd_data, 0);
        end
        idle();
        chk("postreset_nodone", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
